// File: rtl/gpi_core.sv
// General purpose input slot core: 2-FF synchronizer, per-bit debouncer,
// rising-edge flags (write-1-to-clear) and a masked level interrupt.
module gpi_core #(
  parameter int DATA_WIDTH = 16,
  parameter int DB_CYCLES  = 2_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  read,
  input  logic                  write,
  input  logic [4:0]            reg_addr,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  irq
);

  localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [4:0] ADDR_DATA = 5'h00;
  localparam logic [4:0] ADDR_EDGE = 5'h01;
  localparam logic [4:0] ADDR_MASK = 5'h02;

  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] db;
  logic [CW-1:0]         cnt [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] accept;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] edge_flag;
  logic [DATA_WIDTH-1:0] mask;
  logic                  wr_en;
  logic                  unused;

  // Reads have no side effects; upper write-data bits are don't-care.
  assign unused = ^{read, wr_data};
  assign wr_en  = cs && write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
    end
  end

  // A bit is accepted on the cycle its counter has seen DB_CYCLES-1 prior differing cycles.
  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      accept[i] = (sync2[i] != db[i]) && (cnt[i] == CNT_LAST);
      rise[i]   = accept[i] && sync2[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < DATA_WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A new rise wins over a simultaneous clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_flag <= '0;
    end else if (wr_en && reg_addr == ADDR_EDGE) begin
      edge_flag <= (edge_flag & ~wr_data[DATA_WIDTH-1:0]) | rise;
    end else begin
      edge_flag <= edge_flag | rise;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
    end else if (wr_en && reg_addr == ADDR_MASK) begin
      mask <= wr_data[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      ADDR_DATA: rd_data = 32'(db);
      ADDR_EDGE: rd_data = 32'(edge_flag);
      ADDR_MASK: rd_data = 32'(mask);
      default:   rd_data = '0;
    endcase
  end

  assign irq = |(edge_flag & mask);

endmodule
